// File: rtl/pwm_multi_dt.sv
// rtl/pwm_multi_dt.sv - multi-channel complementary PWM with shadowed duty and dead-time insertion
module pwm_multi_dt #(
    parameter int WIDTH    = 11,
    parameter int NUM_CH   = 2,
    parameter int DT_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [WIDTH-1:0]          period,
    input  logic [NUM_CH-1:0]         duty_wr,
    input  logic [NUM_CH*WIDTH-1:0]   duty_in,
    input  logic [DT_WIDTH-1:0]       dead_time,
    output logic [NUM_CH-1:0]         pwm_hi,
    output logic [NUM_CH-1:0]         pwm_lo,
    output logic                      cycle_start
);

    localparam logic [1:0] ST_SAFE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_DT   = 2'd2;
    localparam logic [1:0] ST_HI   = 2'd3;

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    period_act_q, period_act_d;
    logic                cycle_start_q, cycle_start_d;
    logic [WIDTH-1:0]    duty_pend_q [NUM_CH];
    logic [WIDTH-1:0]    duty_pend_d [NUM_CH];
    logic [WIDTH-1:0]    duty_act_q  [NUM_CH];
    logic [WIDTH-1:0]    duty_act_d  [NUM_CH];
    logic [WIDTH-1:0]    duty_in_ch  [NUM_CH];
    logic [NUM_CH-1:0]   raw_q, raw_d;
    logic [1:0]          state_q [NUM_CH];
    logic [1:0]          state_d [NUM_CH];
    logic [DT_WIDTH-1:0] dtc_q   [NUM_CH];
    logic [DT_WIDTH-1:0] dtc_d   [NUM_CH];
    logic                wrap;

    assign wrap        = (cnt_q == period_act_q);
    assign cycle_start = cycle_start_q;

    // Shared period counter; the new period is only adopted at the wrap point
    always_comb begin
        cnt_d         = cnt_q;
        period_act_d  = period_act_q;
        cycle_start_d = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d         = '0;
            period_act_d  = period;
            cycle_start_d = 1'b1;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Duty shadowing: pending register takes writes anytime, active copy only at wrap
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            duty_in_ch[i]  = duty_in[i*WIDTH +: WIDTH];
            duty_pend_d[i] = duty_wr[i] ? duty_in_ch[i] : duty_pend_q[i];
            duty_act_d[i]  = duty_act_q[i];
            // Write-through: a write landing on the wrap cycle goes live immediately
            if (en && wrap) begin
                duty_act_d[i] = duty_pend_d[i];
            end
            raw_d[i] = en && (cnt_q < duty_act_q[i]);
        end
    end

    // Per-channel output FSM; every level change passes through DT unless dead_time is zero
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            dtc_d[i]   = dtc_q[i];
            if (!en) begin
                state_d[i] = ST_SAFE;
            end else begin
                case (state_q[i])
                    ST_SAFE: begin
                        if (dead_time == '0) begin
                            state_d[i] = raw_q[i] ? ST_HI : ST_LO;
                        end else begin
                            state_d[i] = ST_DT;
                            dtc_d[i]   = dead_time;
                        end
                    end
                    ST_LO: begin
                        if (raw_q[i]) begin
                            if (dead_time == '0) begin
                                state_d[i] = ST_HI;
                            end else begin
                                state_d[i] = ST_DT;
                                dtc_d[i]   = dead_time;
                            end
                        end
                    end
                    ST_HI: begin
                        if (!raw_q[i]) begin
                            if (dead_time == '0) begin
                                state_d[i] = ST_LO;
                            end else begin
                                state_d[i] = ST_DT;
                                dtc_d[i]   = dead_time;
                            end
                        end
                    end
                    ST_DT: begin
                        dtc_d[i] = dtc_q[i] - DT_WIDTH'(1);
                        // Exit level follows raw_q at exit, so short pulses get absorbed
                        if (dtc_q[i] <= DT_WIDTH'(1)) begin
                            state_d[i] = raw_q[i] ? ST_HI : ST_LO;
                        end
                    end
                    default: begin
                        state_d[i] = ST_SAFE;
                    end
                endcase
            end
        end
    end

    // Gate drives decoded straight from the state register so hi and lo can never overlap
    always_comb begin
        pwm_hi = '0;
        pwm_lo = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_hi[i] = (state_q[i] == ST_HI);
            pwm_lo[i] = (state_q[i] == ST_LO);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            period_act_q  <= '0;
            cycle_start_q <= 1'b0;
            raw_q         <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_pend_q[i] <= '0;
                duty_act_q[i]  <= '0;
                state_q[i]     <= ST_SAFE;
                dtc_q[i]       <= '0;
            end
        end else begin
            cnt_q         <= cnt_d;
            period_act_q  <= period_act_d;
            cycle_start_q <= cycle_start_d;
            raw_q         <= raw_d;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_pend_q[i] <= duty_pend_d[i];
                duty_act_q[i]  <= duty_act_d[i];
                state_q[i]     <= state_d[i];
                dtc_q[i]       <= dtc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_dt.sv
// tb/tb_pwm_multi_dt.sv - directed self-checking bench for pwm_multi_dt
module tb_pwm_multi_dt;

    localparam int WIDTH    = 11;
    localparam int NUM_CH   = 2;
    localparam int DT_WIDTH = 6;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    en = 1'b0;
    logic [WIDTH-1:0]        period = '0;
    logic [NUM_CH-1:0]       duty_wr = '0;
    logic [NUM_CH*WIDTH-1:0] duty_in = '0;
    logic [DT_WIDTH-1:0]     dead_time = '0;
    logic [NUM_CH-1:0]       pwm_hi;
    logic [NUM_CH-1:0]       pwm_lo;
    logic                    cycle_start;

    int n_tests = 0;
    int n_fail  = 0;
    int hi_n [NUM_CH];
    int lo_n [NUM_CH];
    int off_n[NUM_CH];
    int cs_n;
    int compl_err;
    int overlap_n = 0;

    pwm_multi_dt #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DT_WIDTH(DT_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .period     (period),
        .duty_wr    (duty_wr),
        .duty_in    (duty_in),
        .dead_time  (dead_time),
        .pwm_hi     (pwm_hi),
        .pwm_lo     (pwm_lo),
        .cycle_start(cycle_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NUM_CH; c++) begin
            hi_n[c] = 0; lo_n[c] = 0; off_n[c] = 0;
        end
        cs_n = 0;
        compl_err = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            if (pwm_hi[c] === 1'b1) hi_n[c]++;
            if (pwm_lo[c] === 1'b1) lo_n[c]++;
            if (pwm_hi[c] === 1'b0 && pwm_lo[c] === 1'b0) off_n[c]++;
            if (pwm_hi[c] === 1'b1 && pwm_lo[c] === 1'b1) overlap_n++;
        end
        if (cycle_start === 1'b1) cs_n++;
        if (pwm_lo !== ~pwm_hi) compl_err++;
    endtask

    task automatic write_duty(input logic [NUM_CH-1:0] mask, input logic [WIDTH-1:0] d0,
                              input logic [WIDTH-1:0] d1);
        duty_in = {d1, d0};
        duty_wr = mask;
        tick();
        duty_wr = '0;
    endtask

    task automatic wait_cs();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            seen = cycle_start;
        end
        check("wait_cycle_start", seen, 1);
    endtask

    initial begin
        logic found;
        int   off;
        clear_counts();

        // Reset state
        repeat (3) tick();
        check("rst_hi", pwm_hi, 0);
        check("rst_lo", pwm_lo, 0);
        check("rst_cs", cycle_start, 0);
        rst_n = 1'b1;

        // Basic, dead_time = 0
        period = 11'd9;
        write_duty(2'b11, 11'd3, 11'd7);
        en = 1'b1;
        repeat (25) tick();
        clear_counts();
        repeat (10) tick();
        check("basic_hi0", hi_n[0], 3);
        check("basic_lo0", lo_n[0], 7);
        check("basic_hi1", hi_n[1], 7);
        check("basic_lo1", lo_n[1], 3);
        check("basic_cs", cs_n, 1);
        check("basic_compl", compl_err, 0);

        // Dead time 3 over a 20-clock period
        period = 11'd19;
        dead_time = 6'd3;
        write_duty(2'b01, 11'd10, 11'd7);
        repeat (60) tick();
        clear_counts();
        repeat (20) tick();
        check("dt_hi0", hi_n[0], 7);
        check("dt_lo0", lo_n[0], 7);
        check("dt_off0", off_n[0], 6);

        // Shadow update mid-period: 4 -> 12 written at cnt=6
        dead_time = 6'd0;
        write_duty(2'b01, 11'd4, 11'd7);
        repeat (50) tick();
        wait_cs();
        tick();
        clear_counts();
        for (int i = 2; i <= 21; i++) begin
            tick();
            if (i == 6) begin
                duty_in = {11'd7, 11'd12};
                duty_wr = 2'b01;
            end else begin
                duty_wr = 2'b00;
            end
        end
        check("shadow_cur", hi_n[0], 4);
        clear_counts();
        repeat (20) tick();
        check("shadow_next", hi_n[0], 12);

        // Write coincident with wrap goes live in the period just starting
        wait_cs();
        repeat (19) tick();
        duty_in = {11'd7, 11'd4};
        duty_wr = 2'b01;
        tick();
        duty_wr = 2'b00;
        tick();
        clear_counts();
        repeat (20) tick();
        check("write_through", hi_n[0], 4);

        // Boundaries: duty 0, duty period+1, duty max
        period = 11'd9;
        write_duty(2'b11, 11'd0, 11'd10);
        repeat (50) tick();
        clear_counts();
        repeat (20) tick();
        check("duty0_hi", hi_n[0], 0);
        check("duty0_lo", lo_n[0], 20);
        check("duty10_hi", hi_n[1], 20);
        write_duty(2'b10, 11'd0, 11'd2047);
        repeat (30) tick();
        clear_counts();
        repeat (20) tick();
        check("duty2047_hi", hi_n[1], 20);

        // period = 0: counter stuck, cycle_start every clock
        period = 11'd0;
        repeat (30) tick();
        clear_counts();
        repeat (10) tick();
        check("p0_cs", cs_n, 10);
        check("p0_cnt", dut.cnt_q, 0);

        // Drop en while channel 0 is high
        period = 11'd9;
        write_duty(2'b01, 11'd5, 11'd2047);
        repeat (40) tick();
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            found = pwm_hi[0];
        end
        check("en_hi_seen", found, 1);
        en = 1'b0;
        tick();
        check("en0_hi", pwm_hi[0], 0);
        check("en0_lo", pwm_lo[0], 0);
        check("en0_cnt", dut.cnt_q, 0);
        check("en0_cs", cycle_start, 0);

        // Re-enable with dead_time 5
        dead_time = 6'd5;
        en = 1'b1;
        found = 1'b0;
        off = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (pwm_hi[0] || pwm_lo[0]) found = 1'b1;
            else off++;
        end
        check("reen_dt_len", off, 5);
        check("reen_level", pwm_hi[0], 1);

        // Async reset while channel 0 sits in dead time
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            found = !pwm_hi[0] && !pwm_lo[0];
        end
        check("dt_seen", found, 1);
        check("pre_rst_hi1", pwm_hi[1], 1);
        rst_n = 1'b0;
        #1;
        check("arst_hi", pwm_hi, 0);
        check("arst_lo", pwm_lo, 0);
        check("arst_cnt", dut.cnt_q, 0);
        check("arst_period", dut.period_act_q, 0);
        check("arst_duty", dut.duty_act_q[0], 0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Short pulse absorbed by dead time
        period = 11'd15;
        dead_time = 6'd4;
        write_duty(2'b01, 11'd2, 11'd0);
        en = 1'b1;
        repeat (60) tick();
        clear_counts();
        repeat (16) tick();
        check("short_hi", hi_n[0], 0);
        check("short_lo", lo_n[0], 12);
        check("short_off", off_n[0], 4);

        check("no_overlap", overlap_n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
